// File: rtl/jtkcpu_stack.sv
// jtkcpu_stack -- stack transfer engine for the KONAMI-2 CPU core.
//
// Answers the sequencer's push/pull strobes. On accept it latches a register
// mask, the stack selector and the stack pointer, then moves one byte per
// enabled bus cycle between the register file and memory. It holds busy
// while working and pulses done/sp_we when finished.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cen                 clock enable; nothing advances while low
//   mem_busy            bus stall; the current byte is held while high
//   psh_go/pul_go       push/pull using postbyte as the mask
//   psh_all/psh_cc/psh_pc, pul_pc, rti   fixed-mask requests
//   sel_u               1 = operate on U, 0 = on S
//   postbyte            mask: b0 CC b1 A b2 B b3 DP b4 X b5 Y b6 other-SP b7 PC
//   cc,a,b,dp,x,y,u,s,pc  live register values
//   din                 memory read data
//   addr, dout, we      bus address, write data, write strobe
//   busy, done          transfer in progress, one-cycle completion pulse
//   sp_out, sp_we       updated stack pointer and its load strobe
//   pul_data, pul_we    pulled value and one-hot register load strobe
module jtkcpu_stack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        mem_busy,
  input  logic        psh_go,
  input  logic        pul_go,
  input  logic        psh_all,
  input  logic        psh_cc,
  input  logic        psh_pc,
  input  logic        pul_pc,
  input  logic        rti,
  input  logic        sel_u,
  input  logic [7:0]  postbyte,
  input  logic [7:0]  cc,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  dp,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] u,
  input  logic [15:0] s,
  input  logic [15:0] pc,
  input  logic [7:0]  din,
  output logic [15:0] addr,
  output logic [7:0]  dout,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic [15:0] sp_out,
  output logic        sp_we,
  output logic [15:0] pul_data,
  output logic [7:0]  pul_we
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUSH,
    ST_PULL,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  mask_q, mask_d;
  logic        sel_u_q, sel_u_d;
  logic [15:0] sp_q, sp_d;
  logic        phase_q, phase_d;   // 1 = second byte of a 16-bit register
  logic        rti_q, rti_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  pul_we_q, pul_we_d;
  logic [15:0] pul_data_q, pul_data_d;

  logic [2:0]  push_idx, pull_idx;
  logic [7:0]  push_bit, pull_bit;
  logic [15:0] push_val;
  logic [7:0]  push_byte;

  logic        acc, acc_push, acc_rti;
  logic [7:0]  acc_mask;

  // Push works from the highest set mask bit down, pull from the lowest up.
  always_comb begin
    push_idx = '0;
    pull_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (mask_q[i]) push_idx = 3'(i);
    end
    for (int unsigned i = 8; i > 0; i--) begin
      if (mask_q[i-1]) pull_idx = 3'(i-1);
    end
    push_bit = 8'b1 << push_idx;
    pull_bit = 8'b1 << pull_idx;
    unique case (push_idx)
      3'd0: push_val = {8'h00, cc};
      3'd1: push_val = {8'h00, a};
      3'd2: push_val = {8'h00, b};
      3'd3: push_val = {8'h00, dp};
      3'd4: push_val = x;
      3'd5: push_val = y;
      3'd6: push_val = sel_u_q ? s : u;
      3'd7: push_val = pc;
    endcase
    // Low byte goes out first so it lands at the higher address.
    push_byte = phase_q ? push_val[15:8] : push_val[7:0];
  end

  // Request decode, fixed priority.
  always_comb begin
    acc      = 1'b1;
    acc_push = 1'b0;
    acc_rti  = 1'b0;
    acc_mask = '0;
    if (psh_all) begin
      acc_push = 1'b1;
      acc_mask = 8'hFF;
    end else if (psh_cc) begin
      acc_push = 1'b1;
      acc_mask = 8'h81;
    end else if (psh_pc) begin
      acc_push = 1'b1;
      acc_mask = 8'h80;
    end else if (psh_go) begin
      acc_push = 1'b1;
      acc_mask = postbyte;
    end else if (rti) begin
      acc_rti  = 1'b1;
      acc_mask = 8'h01;
    end else if (pul_pc) begin
      acc_mask = 8'h80;
    end else if (pul_go) begin
      acc_mask = postbyte;
    end else begin
      acc = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    sel_u_d    = sel_u_q;
    sp_d       = sp_q;
    phase_d    = phase_q;
    rti_d      = rti_q;
    hi_d       = hi_q;
    pul_we_d   = pul_we_q;
    pul_data_d = pul_data_q;
    if (cen) begin
      pul_we_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (acc) begin
            mask_d  = acc_mask;
            sel_u_d = sel_u;
            sp_d    = sel_u ? u : s;
            phase_d = 1'b0;
            rti_d   = acc_rti;
            if (acc_mask == '0)  state_d = ST_DONE;
            else if (acc_push)   state_d = ST_PUSH;
            else                 state_d = ST_PULL;
          end
        end
        ST_PUSH: begin
          if (!mem_busy) begin
            sp_d = sp_q - 16'd1;
            if (!push_idx[2] || phase_q) begin
              phase_d = 1'b0;
              mask_d  = mask_q & ~push_bit;
              if (mask_d == '0) state_d = ST_DONE;
            end else begin
              phase_d = 1'b1;
            end
          end
        end
        ST_PULL: begin
          if (!mem_busy) begin
            sp_d = sp_q + 16'd1;
            if (pull_idx[2] && !phase_q) begin
              hi_d    = din;
              phase_d = 1'b1;
            end else begin
              phase_d    = 1'b0;
              pul_we_d   = pull_bit;
              pul_data_d = pull_idx[2] ? {hi_q, din} : {8'h00, din};
              mask_d     = mask_q & ~pull_bit;
              // RTI starts with CC only; its E bit then decides the rest.
              if (rti_q) begin
                mask_d = din[7] ? 8'hFE : 8'h80;
                rti_d  = 1'b0;
              end
              if (mask_d == '0) state_d = ST_DONE;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      sel_u_q    <= 1'b0;
      sp_q       <= '0;
      phase_q    <= 1'b0;
      rti_q      <= 1'b0;
      hi_q       <= '0;
      pul_we_q   <= '0;
      pul_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      sel_u_q    <= sel_u_d;
      sp_q       <= sp_d;
      phase_q    <= phase_d;
      rti_q      <= rti_d;
      hi_q       <= hi_d;
      pul_we_q   <= pul_we_d;
      pul_data_q <= pul_data_d;
    end
  end

  always_comb begin
    busy     = (state_q == ST_PUSH) || (state_q == ST_PULL);
    done     = (state_q == ST_DONE);
    sp_we    = (state_q == ST_DONE);
    we       = (state_q == ST_PUSH);
    addr     = '0;
    dout     = '0;
    if (state_q == ST_PUSH) begin
      addr = sp_q - 16'd1;
      dout = push_byte;
    end else if (state_q == ST_PULL) begin
      addr = sp_q;
    end
    sp_out   = sp_q;
    pul_we   = pul_we_q;
    pul_data = pul_data_q;
  end

endmodule

// File: tb/tb_jtkcpu_stack.sv
// Self-checking bench for jtkcpu_stack: a behavioural model turns each request
// into the expected per-cycle bus/strobe sequence, which is compared against
// the DUT every cycle; a few literal values pin the model itself.
module tb_jtkcpu_stack;

  logic        clk = 1'b0;
  logic        rst_n, cen, mem_busy, sel_u;
  logic [6:0]  req;
  logic [7:0]  postbyte, cc, a, b, dp, din;
  logic [15:0] x, y, u, s, pc;
  logic [15:0] addr, sp_out, pul_data;
  logic [7:0]  dout, pul_we;
  logic        we, busy, done, sp_we;

  always #5 clk = ~clk;

  // req bits: 6 psh_all, 5 psh_cc, 4 psh_pc, 3 psh_go, 2 rti, 1 pul_pc, 0 pul_go
  jtkcpu_stack dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .mem_busy(mem_busy),
    .psh_go(req[3]), .pul_go(req[0]), .psh_all(req[6]), .psh_cc(req[5]),
    .psh_pc(req[4]), .pul_pc(req[1]), .rti(req[2]), .sel_u(sel_u),
    .postbyte(postbyte), .cc(cc), .a(a), .b(b), .dp(dp),
    .x(x), .y(y), .u(u), .s(s), .pc(pc), .din(din),
    .addr(addr), .dout(dout), .we(we), .busy(busy), .done(done),
    .sp_out(sp_out), .sp_we(sp_we), .pul_data(pul_data), .pul_we(pul_we)
  );

  // Bus memory
  logic [7:0]  mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (we && cen && !mem_busy && rst_n) mem[addr] <= dout;
  end
  assign din = mem[addr];

  typedef struct packed {
    logic        busy, done, we, sp_we, chk_sp, chk_zero;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [15:0] sp_out;
    logic [7:0]  pul_we;
    logic [15:0] pul_data;
    logic [1:0]  ctl;     // input for this cycle: 0 run, 1 mem_busy, 2 cen low
  } cyc_t;

  cyc_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc_no   = 0;

  // model state
  int          m_byte, m_st_byte, m_st_n, m_done_idx;
  logic [1:0]  m_st_kind;
  logic [7:0]  m_pw;
  logic [15:0] m_pd, m_sp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, act, exp);
  endtask

  function automatic logic [15:0] regval(input int i, input logic su);
    case (i)
      0: return {8'h00, cc};
      1: return {8'h00, a};
      2: return {8'h00, b};
      3: return {8'h00, dp};
      4: return x;
      5: return y;
      6: return su ? s : u;
      default: return pc;
    endcase
  endfunction

  // One transferred byte: its stall cycles then its advance cycle.
  task automatic emit(input logic w, input logic [15:0] ad, input logic [7:0] d);
    cyc_t       r;
    logic [7:0] cur;
    logic [1:0] prev;
    int         n;
    cur  = m_pw;
    prev = 2'd0;
    n    = (m_byte == m_st_byte) ? m_st_n : 0;
    for (int j = 0; j <= n; j++) begin
      if (j > 0 && prev != 2'd2) cur = 8'h00;
      r          = '0;
      r.busy     = 1'b1;
      r.we       = w;
      r.addr     = ad;
      r.dout     = w ? d : 8'h00;
      r.pul_we   = cur;
      r.pul_data = m_pd;
      r.ctl      = (j < n) ? m_st_kind : 2'd0;
      prev       = r.ctl;
      exp_q.push_back(r);
    end
    m_byte++;
    m_pw = 8'h00;
  endtask

  task automatic build(input logic [6:0] rq, input logic su, input logic [7:0] pb);
    logic [7:0]  m;
    logic        push, is_rti;
    logic [15:0] v;
    logic [7:0]  dd, hi;
    cyc_t        r;
    int          nb;
    push = 1'b0; is_rti = 1'b0;
    if (rq[6])      begin push = 1'b1; m = 8'hFF; end
    else if (rq[5]) begin push = 1'b1; m = 8'h81; end
    else if (rq[4]) begin push = 1'b1; m = 8'h80; end
    else if (rq[3]) begin push = 1'b1; m = pb;    end
    else if (rq[2]) begin is_rti = 1'b1; m = 8'h01; end
    else if (rq[1]) m = 8'h80;
    else            m = pb;
    exp_q.delete();
    m_byte = 0; m_pw = 8'h00; m_pd = pul_data_prev;
    m_sp = su ? u : s;
    if (push) begin
      for (int i = 7; i >= 0; i--) begin
        if (m[i]) begin
          v  = regval(i, su);
          nb = (i >= 4) ? 2 : 1;
          for (int k = 0; k < nb; k++) begin
            emit(1'b1, m_sp - 16'd1, (k == 0) ? v[7:0] : v[15:8]);
            m_sp = m_sp - 16'd1;
          end
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          nb = (i >= 4) ? 2 : 1;
          hi = 8'h00; dd = 8'h00;
          for (int k = 0; k < nb; k++) begin
            dd = mem[m_sp];
            emit(1'b0, m_sp, 8'h00);
            if (k == 0) hi = dd;
            m_sp = m_sp + 16'd1;
          end
          m_pw = 8'h01 << i;
          m_pd = (nb == 2) ? {hi, dd} : {8'h00, dd};
          if (is_rti && i == 0) m = dd[7] ? 8'hFE : 8'h80;
        end
      end
    end
    m_done_idx = exp_q.size() + 1;
    r = '0;
    r.done = 1'b1; r.sp_we = 1'b1; r.chk_sp = 1'b1; r.sp_out = m_sp;
    r.pul_we = m_pw; r.pul_data = m_pd;
    exp_q.push_back(r);
    r = '0;
    exp_q.push_back(r);
  endtask

  // last pulled value, so the model knows what pul_data holds before an op
  logic [15:0] pul_data_prev = 16'h0000;

  task automatic compare(input cyc_t e);
    chk("busy",   32'(busy),   32'(e.busy));
    chk("done",   32'(done),   32'(e.done));
    chk("we",     32'(we),     32'(e.we));
    chk("sp_we",  32'(sp_we),  32'(e.sp_we));
    chk("pul_we", 32'(pul_we), 32'(e.pul_we));
    if (e.busy || e.chk_zero) chk("addr", 32'(addr), 32'(e.addr));
    if (e.we || e.chk_zero)   chk("dout", 32'(dout), 32'(e.dout));
    if (e.chk_sp)             chk("sp_out", 32'(sp_out), 32'(e.sp_out));
    if (e.pul_we != 8'h00 || e.chk_zero) chk("pul_data", 32'(pul_data), 32'(e.pul_data));
  endtask

  task automatic preload(input logic [15:0] ad, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = ad; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic run(input logic [6:0] rq, input logic su, input logic [7:0] pb,
                     input int st_byte, input int st_n, input logic [1:0] st_kind,
                     input int rst_at, input logic keep);
    cyc_t e;
    int   i;
    sel_u = su; postbyte = pb; req = rq;
    @(posedge clk); #1;
    if (!keep) req = 7'd0;
    m_st_byte = st_byte; m_st_n = st_n; m_st_kind = st_kind;
    build(rq, su, pb);
    if (rst_at != 0) begin
      while (exp_q.size() > rst_at) exp_q.delete(exp_q.size() - 1);
      e = '0; e.chk_zero = 1'b1; e.chk_sp = 1'b1;
      exp_q.push_back(e);
      exp_q.push_back(e);
      m_pd = 16'h0000;
    end
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc_no   = i + 1;
      cen      = (e.ctl != 2'd2);
      mem_busy = (e.ctl == 2'd1);
      rst_n    = !(rst_at != 0 && i + 1 == rst_at);
      if (exp_q.size() == 0) req = 7'd0;
      @(negedge clk);
      compare(e);
      @(posedge clk); #1;
      i++;
    end
    cen = 1'b1; mem_busy = 1'b0; rst_n = 1'b1; req = 7'd0;
    pul_data_prev = m_pd;
  endtask

  initial begin
    cyc_t z;
    rst_n = 1'b0; cen = 1'b1; mem_busy = 1'b0; req = 7'd0; sel_u = 1'b0;
    postbyte = 8'h00; cc = 8'h00; a = 8'h00; b = 8'h00; dp = 8'h00;
    x = 16'h0; y = 16'h0; u = 16'h0; s = 16'h0; pc = 16'h0;
    ld_en = 1'b0; ld_addr = 16'h0; ld_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    z = '0; z.chk_zero = 1'b1; z.chk_sp = 1'b1;
    compare(z);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PSHS A,B with a request held through the whole transfer
    s = 16'h1000; a = 8'h11; b = 8'h22;
    run(7'b0001000, 1'b0, 8'h06, -1, 0, 2'd0, 0, 1'b1);
    chk("pshs_mem0fff", 32'(mem[16'h0FFF]), 32'h22);
    chk("pshs_mem0ffe", 32'(mem[16'h0FFE]), 32'h11);
    chk("pshs_model_sp", 32'(m_sp), 32'h0FFE);
    chk("pshs_model_done", 32'(m_done_idx), 32'd3);

    // IRQ-style full push
    s = 16'h2000; pc = 16'h1234; u = 16'h5678; y = 16'h9ABC; x = 16'hDEF0;
    dp = 8'h01; b = 8'h02; a = 8'h03; cc = 8'h84;
    run(7'b1000000, 1'b0, 8'h00, -1, 0, 2'd0, 0, 1'b0);
    chk("all_mem1fff", 32'(mem[16'h1FFF]), 32'h34);
    chk("all_mem1ff4", 32'(mem[16'h1FF4]), 32'h84);
    chk("all_model_sp", 32'(m_sp), 32'h1FF4);
    chk("all_model_done", 32'(m_done_idx), 32'd13);

    // RTS
    preload(16'h1FF4, 8'hAB);
    preload(16'h1FF5, 8'hCD);
    s = 16'h1FF4;
    run(7'b0000010, 1'b0, 8'h00, -1, 0, 2'd0, 0, 1'b0);
    chk("rts_model_pd", 32'(m_pd), 32'hABCD);
    chk("rts_model_sp", 32'(m_sp), 32'h1FF6);

    // RTI, E clear: CC then PC
    preload(16'h1FF4, 8'h04);
    run(7'b0000100, 1'b0, 8'h00, -1, 0, 2'd0, 0, 1'b0);
    chk("rti0_model_sp", 32'(m_sp), 32'h1FF7);
    chk("rti0_model_done", 32'(m_done_idx), 32'd4);

    // RTI, E set: the whole frame
    preload(16'h1FF4, 8'h84);
    preload(16'h1FF5, 8'h03);
    run(7'b0000100, 1'b0, 8'h00, -1, 0, 2'd0, 0, 1'b0);
    chk("rti1_model_pd", 32'(m_pd), 32'h1234);
    chk("rti1_model_done", 32'(m_done_idx), 32'd13);

    // JSR across the wrap point with a 2-cycle bus stall on the first byte
    s = 16'h0001; pc = 16'hBEEF;
    run(7'b0010000, 1'b0, 8'h00, 0, 2, 2'd1, 0, 1'b0);
    chk("wrap_mem0000", 32'(mem[16'h0000]), 32'hEF);
    chk("wrap_memffff", 32'(mem[16'hFFFF]), 32'hBE);
    chk("wrap_model_sp", 32'(m_sp), 32'hFFFF);
    chk("wrap_model_done", 32'(m_done_idx), 32'd5);

    // PSHU S,X
    sel_u = 1'b1; u = 16'h4000; s = 16'h1357; x = 16'h2468;
    run(7'b0001000, 1'b1, 8'h50, -1, 0, 2'd0, 0, 1'b0);
    chk("pshu_mem3fff", 32'(mem[16'h3FFF]), 32'h57);
    chk("pshu_mem3ffc", 32'(mem[16'h3FFC]), 32'h24);

    // PULU CC,A with cen low for 2 cycles on the A byte
    u = 16'h3FFC;
    run(7'b0000001, 1'b1, 8'h03, 1, 2, 2'd2, 0, 1'b0);
    chk("pulu_model_pd", 32'(m_pd), 32'h0068);

    // Priority: psh_pc beats rti and pul_go
    s = 16'h5000; pc = 16'hA5C3;
    run(7'b0010101, 1'b0, 8'hFF, -1, 0, 2'd0, 0, 1'b0);
    chk("prio_mem4fff", 32'(mem[16'h4FFF]), 32'hC3);

    // Reset during the 5th byte of a full push
    s = 16'h6000;
    run(7'b1000000, 1'b0, 8'h00, -1, 0, 2'd0, 5, 1'b0);

    // Empty mask
    s = 16'h3000;
    run(7'b0001000, 1'b0, 8'h00, -1, 0, 2'd0, 0, 1'b0);
    chk("empty_model_done", 32'(m_done_idx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jtkcpu_stack.md
Name: jtkcpu_stack

Overview:
- Stack transfer engine for the KONAMI-2 CPU core. It is the responder to the microcode sequencer's push/pull request strobes.
- On a request it works through a register mask and moves one byte per enabled bus cycle between the register file and memory, updating the selected stack pointer.
- It holds busy while active and pulses done so the sequencer can resume.
- It serves PSHS/PSHU/PULS/PULU, JSR/RTS, interrupt entry and RTI.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cen  in  1  clock enable; all state advances only when high
- mem_busy  in  1  bus stall; no byte transfer while high
- psh_go  in  1  start push using mask postbyte
- pul_go  in  1  start pull using mask postbyte
- psh_all  in  1  push with mask 8'hFF (IRQ/NMI entry)
- psh_cc  in  1  push with mask 8'h81 (FIRQ entry)
- psh_pc  in  1  push with mask 8'h80 (JSR/BSR)
- pul_pc  in  1  pull with mask 8'h80 (RTS)
- rti  in  1  pull CC first, then the rest per E bit
- sel_u  in  1  1 = operate on U, 0 = on S
- postbyte  in  8  register mask: b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 other SP (S when sel_u else U), b7 PC
- cc, a, b, dp  in  8 each  register values
- x, y, u, s, pc  in  16 each  register values
- din  in  8  memory read data
- addr  out  16  bus address
- dout  out  8  write data
- we  out  1  byte write strobe
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- sp_out  out  16  updated stack pointer
- sp_we  out  1  load sp_out into U (sel_u) or S; coincident with done
- pul_data  out  16  assembled pulled value; 8-bit registers in [7:0]
- pul_we  out  8  one-hot load strobe, same bit order as the mask

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE. busy, done, we, sp_we, pul_we = 0; addr, dout, sp_out, pul_data = 0. Reset mid-transfer aborts immediately, with no further we.
- States:
  - IDLE: accept a request when cen=1.
  - PUSH / PULL: one byte per cycle with cen=1 and mem_busy=0.
  - DONE: done=1, sp_we=1, busy=0, return to IDLE.
- Request priority when several are high in the same cycle: psh_all > psh_cc > psh_pc > psh_go > rti > pul_pc > pul_go.
- Requests are ignored while busy=1.
- On accept, latch the mask, sel_u, and the SP (u or s). Register inputs are sampled live and must be held stable by the core.
- busy=1 from the cycle after accept until the DONE cycle, exclusive.
- Push order is PC, other SP, Y, X, DP, B, A, CC, skipping clear mask bits.
- 16-bit registers are pushed low byte first.
- Each push byte: addr = sp-1, we=1, dout = byte; on the advance edge sp <= sp-1.
- Pull order is the reverse: CC, A, B, DP, X, Y, other SP, PC; 16-bit registers high byte first.
- Each pull byte: addr = sp, we=0; din is captured on the advance edge and sp <= sp+1.
- pul_we bit pulses for one cycle after the last byte of that register, with pul_data valid in that same cycle.
- RTI: pull CC. If the captured din[7] (E) = 1, the remaining mask becomes 8'hFE; otherwise it becomes 8'h80.
- SP arithmetic is modulo 2^16 (0x0000-1 = 0xFFFF, 0xFFFF+1 = 0x0000).
- Latency: n bytes with no stalls → busy for n cycles, done on cycle n+1 after accept.
- An empty mask (postbyte 0) goes straight to DONE the cycle after accept, with sp_out = the original SP and no bus cycles.
- cen=0 freezes all state and outputs. we stays asserted if it was, but no advance occurs. mem_busy=1 likewise holds the current byte.

Test Plan:
- PSHS postbyte 8'h06, S=16'h1000, A=8'h11, B=8'h22 → writes 0FFF←22, then 0FFE←11; done on the 3rd cycle after accept; sp_out=0FFE, sp_we=1.
- psh_all, S=16'h2000, PC=1234, U=5678, Y=9ABC, X=DEF0, DP=01, B=02, A=03, CC=84 → 12 writes 1FFF←34, 1FFE←12, … 1FF4←84; sp_out=1FF4.
- pul_pc, S=1FF4, mem[1FF4]=AB, mem[1FF5]=CD → pul_we=8'h80 with pul_data=ABCD; sp_out=1FF6.
- rti, S=1FF4, mem[1FF4]=04 (E=0) → 3 reads, PC only, sp_out=1FF7. Repeat with mem[1FF4]=84 → 12 reads, with pul_we strobes in order 01,02,04,08,10,20,40,80.
- Wrap and stall: S=0001, psh_pc, PC=BEEF, mem_busy high for 2 cycles on the first byte → writes 0000←EF (held 3 cycles), then FFFF←BE; sp_out=FFFF.
- Reset mid-op: rst_n low during the 5th byte of psh_all → next cycle busy=0, we=0, done=0. Postbyte 0 → done 1 cycle after accept, no we.
